// File: rtl/jk_pkg.sv
// Shared op codes, FSM state encoding and the per-bit JK next-state rule
// used by the bank and by the scheduler's read-back path.
package jk_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // {j,k} uses the same encoding as the request op field
  function automatic logic jk_bit(input logic cur, input logic j, input logic k);
    logic nxt;
    case ({j, k})
      OP_HOLD: nxt = cur;
      OP_CLR:  nxt = 1'b0;
      OP_SET:  nxt = 1'b1;
      default: nxt = ~cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_bank.sv
// Bank of WIDTH JK flip-flops; q updates on every posedge from j/k (j=k=0 holds).
// Synchronous active-low reset clears the whole bank.
module jk_bank
  import jk_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    for (int b = 0; b < WIDTH; b++) begin
      q_d[b] = jk_bit(q_q[b], j[b], k[b]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_bank_sched.sv
// Round-robin scheduler for a shared JK bank: accept in IDLE, apply for one cycle,
// report rd_q with a done pulse two cycles after accept; requests wait while busy.
module jk_bank_sched
  import jk_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_mask,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      rd_q,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e           state_q, state_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [IW-1:0]    win_q, win_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] rd_q_q, rd_q_d;
  logic [WIDTH-1:0] j, k;
  logic [WIDTH-1:0] bank_q;
  logic [IW-1:0]    pick;
  logic             found;

  // First valid requester at or after the rr pointer, wrapping
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(rr_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    win_d     = win_q;
    op_d      = op_q;
    mask_d    = mask_q;
    rd_q_d    = rd_q_q;
    req_ready = '0;
    done      = '0;
    j         = '0;
    k         = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          req_ready[pick] = 1'b1;
          win_d           = pick;
          op_d            = req_op[2*pick +: 2];
          mask_d          = req_mask[WIDTH*pick +: WIDTH];
          rr_d            = (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
          state_d         = ST_APPLY;
        end
      end
      ST_APPLY: begin
        j = {WIDTH{op_q[1]}} & mask_q;
        k = {WIDTH{op_q[0]}} & mask_q;
        // Capture the value the bank is about to take so rd_q is ready in DONE
        for (int b = 0; b < WIDTH; b++) begin
          rd_q_d[b] = jk_bit(bank_q[b], j[b], k[b]);
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done[win_q] = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Pulses are suppressed while reset is asserted, even mid-operation
    if (!rst) begin
      req_ready = '0;
      done      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      op_q    <= OP_HOLD;
      mask_q  <= '0;
      rd_q_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      rd_q_q  <= rd_q_d;
    end
  end

  jk_bank #(.WIDTH(WIDTH)) u_bank (
    .clk (clk),
    .rst (rst),
    .j   (j),
    .k   (k),
    .q   (bank_q)
  );

  assign q    = bank_q;
  assign rd_q = rd_q_q;
  assign busy = rst && (state_q != ST_IDLE);

endmodule

// File: tb/tb_jk_bank_sched.sv
// Bench for jk_bank_sched: requester driver, cycle-level reference model and
// a done/rd_q scoreboard monitor, with directed scenarios followed by random traffic.
module tb_jk_bank_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [2*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_mask;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      rd_q;
  logic [W-1:0]      q;
  logic              busy;

  jk_bank_sched #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_mask  (req_mask),
    .req_ready (req_ready),
    .done      (done),
    .rd_q      (rd_q),
    .q         (q),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           idx;
    logic [W-1:0] val;
    int           cyc;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [NREQ-1:0] ready_seen = '0;
  logic [NREQ-1:0] keep = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Effect of one op on the whole bank, as plain bitwise arithmetic
  function automatic logic [W-1:0] apply_op(input logic [W-1:0] cur, input logic [1:0] op,
                                            input logic [W-1:0] m);
    case (op)
      2'b01:   return cur & ~m;
      2'b10:   return cur | m;
      2'b11:   return cur ^ m;
      default: return cur;
    endcase
  endfunction

  // Reference model: grant timing/order, busy and live bank value
  int           cyc = 0;
  int           next_free = 0;
  int           last = NREQ - 1;
  int           apply_cyc = -1;
  logic [W-1:0] apply_val = '0;
  logic [W-1:0] model_bank = '0;
  logic [NREQ-1:0] exp_ready;
  int           w;
  exp_t         e_new;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      model_bank = '0;
      sb.delete();
      last       = NREQ - 1;
      next_free  = cyc + 1;
      apply_cyc  = -1;
      chk("reset_ready", 32'(req_ready), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      ready_seen = '0;
    end else begin
      if (cyc == apply_cyc) model_bank = apply_val;
      chk("busy", 32'(busy), 32'(cyc < next_free));
      exp_ready = '0;
      w = -1;
      if (req_valid != '0 && cyc >= next_free) begin
        for (int o = 1; o <= NREQ; o++) begin
          if (w < 0 && req_valid[(last + o) % NREQ]) w = (last + o) % NREQ;
        end
        exp_ready[w] = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("q_live", 32'(q), 32'(model_bank));
      if (w >= 0) begin
        apply_val = apply_op(model_bank, req_op[2*w +: 2], req_mask[W*w +: W]);
        apply_cyc = cyc + 2;
        e_new.idx = w;
        e_new.val = apply_val;
        e_new.cyc = cyc + 2;
        sb.push_back(e_new);
        last      = w;
        next_free = cyc + 3;
      end
      ready_seen = req_ready;
    end
  end

  // Completion monitor: pops the scoreboard whenever done pulses
  int   mcyc = 0;
  exp_t e_pop;
  always @(negedge clk) begin
    mcyc++;
    if (rst) begin
      if (done != '0) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'd0);
        end else begin
          e_pop = sb.pop_front();
          chk("done_idx", 32'(done), 32'(1) << e_pop.idx);
          chk("done_rd_q", 32'(rd_q), 32'(e_pop.val));
          chk("done_latency", 32'(mcyc), 32'(e_pop.cyc));
        end
      end else if (sb.size() != 0 && sb[0].cyc < mcyc) begin
        e_pop = sb.pop_front();
        chk("done_missing", 32'(0), 32'(1) << e_pop.idx);
      end
    end
  end

  // Requester driver
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (ready_seen[i] && !keep[i]) req_valid[i] = 1'b0;
    end
  endtask

  task automatic post(input int i, input logic [1:0] op, input logic [W-1:0] m);
    if (!req_valid[i]) begin
      req_op[2*i +: 2] = op;
      req_mask[W*i +: W] = m;
      req_valid[i] = 1'b1;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (req_valid != '0 || busy); n++) tick();
    chk("drain_timeout", 32'(req_valid != '0 || busy), 32'd0);
  endtask

  task automatic wait_grant(input int i);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      tick();
      got = ready_seen[i];
    end
    chk("grant_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '1;
    req_op    = '0;
    req_mask  = '0;
    tick();
    tick();
    req_valid = '0;
    rst       = 1'b1;
    tick();

    post(0, 2'b10, 8'h0F);
    drain();
    post(0, 2'b11, 8'hFF);
    drain();

    keep = '1;
    for (int i = 0; i < NREQ; i++) post(i, 2'b00, 8'($urandom));
    repeat (16) tick();
    keep = '0;
    drain();

    post(0, 2'b01, 8'hFF);
    drain();
    post(0, 2'b10, 8'hAA);
    drain();
    post(2, 2'b01, 8'h0F);
    drain();
    post(1, 2'b00, 8'hFF);
    drain();
    chk("mask_result", 32'(q), 32'h0000_00A0);

    post(3, 2'b10, 8'hFF);
    wait_grant(3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    post(1, 2'b10, 8'h81);
    post(3, 2'b10, 8'h18);
    drain();

    post(1, 2'b11, 8'h3C);
    wait_grant(1);
    tick();
    post(2, 2'b10, 8'h01);
    drain();

    for (int c = 0; c < 800; c++) begin
      tick();
      rst = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0) post(i, 2'($urandom_range(0, 3)), 8'($urandom));
      end
    end
    rst = 1'b1;
    drain();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
